// File: rtl/alu_operand_seq_if.sv
// alu_operand_seq_if: operand bus, adder side-channel and result handshake for alu_operand_seq.
`default_nettype none

interface alu_operand_seq_if;
   logic       clr;
   logic [7:0] in_data;
   logic [1:0] in_op;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic       add_cin;
   logic [7:0] add_sum;
   logic       add_cout;
   logic [7:0] res_data;
   logic [3:0] res_flags;
   logic       res_valid;
   logic       res_ready;

   modport slave (
      input  clr, in_data, in_op, in_valid, add_sum, add_cout, res_ready,
      output in_ready, add_a, add_b, add_cin, res_data, res_flags, res_valid
   );

   modport master (
      output clr, in_data, in_op, in_valid, add_sum, add_cout, res_ready,
      input  in_ready, add_a, add_b, add_cin, res_data, res_flags, res_valid
   );
endinterface

`default_nettype wire

// File: rtl/alu_operand_seq.sv
// alu_operand_seq: two-byte operand sequencer and flag/result register around an external 8-bit adder.
// Optional feature macro ALU_SUB_EN enables SUB/SBC (operand B inversion); undefined folds them onto ADD/ADC.
`default_nettype none

module alu_operand_seq (
   input  logic                clk,
   input  logic                rst_n,
   alu_operand_seq_if.slave    bus
);

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_EX  = 2'd2,
      S_OUT = 2'd3
   } state_t;

   state_t     state_q;
   logic       in_ready_q;
   logic       res_valid_q;
   logic       cflag_q;
   logic [7:0] add_a_q;
   logic [7:0] add_b_q;
   logic       add_cin_q;
   logic [7:0] res_data_q;
   logic [3:0] res_flags_q;
   logic [7:0] b_eff_d;
   logic       cin_d;

`ifdef ALU_SUB_EN
   logic [1:0] op_q;
   logic [1:0] op_d;

   assign op_d = bus.in_op;

   always_comb begin
      b_eff_d = op_q[1] ? ~bus.in_data : bus.in_data;
      case (op_q)
         2'b00:   cin_d = 1'b0;
         2'b10:   cin_d = 1'b1;
         default: cin_d = cflag_q;
      endcase
   end
`else
   logic op_q;
   logic op_d;
   logic unused_op_hi;

   // Only the carry-use bit matters when subtraction is compiled out.
   assign op_d         = bus.in_op[0];
   assign unused_op_hi = bus.in_op[1];

   always_comb begin
      b_eff_d = bus.in_data;
      cin_d   = op_q ? cflag_q : 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_A;
         in_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
         cflag_q     <= 1'b0;
         op_q        <= '0;
         add_a_q     <= 8'h00;
         add_b_q     <= 8'h00;
         add_cin_q   <= 1'b0;
         res_data_q  <= 8'h00;
         res_flags_q <= 4'h0;
      end else if (bus.clr) begin
         // Abort wins over any handshake; result registers keep their last value.
         state_q     <= S_A;
         in_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
         cflag_q     <= 1'b0;
      end else begin
         case (state_q)
            S_A: begin
               if (bus.in_valid) begin
                  add_a_q <= bus.in_data;
                  op_q    <= op_d;
                  state_q <= S_B;
               end
            end
            S_B: begin
               if (bus.in_valid) begin
                  add_b_q    <= b_eff_d;
                  add_cin_q  <= cin_d;
                  in_ready_q <= 1'b0;
                  state_q    <= S_EX;
               end
            end
            S_EX: begin
               res_data_q  <= bus.add_sum;
               cflag_q     <= bus.add_cout;
               res_flags_q <= {bus.add_sum[7],
                               (bus.add_sum == 8'h00),
                               bus.add_cout,
                               (add_a_q[7] == add_b_q[7]) & (bus.add_sum[7] != add_a_q[7])};
               res_valid_q <= 1'b1;
               state_q     <= S_OUT;
            end
            S_OUT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_A;
               end
            end
            default: begin
               state_q     <= S_A;
               in_ready_q  <= 1'b1;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.add_cin   = add_cin_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_flags = res_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_seq.sv
// tb_alu_operand_seq: directed vectors with a result scoreboard for alu_operand_seq.
`default_nettype none

module tb_alu_operand_seq;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] flags;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   alu_operand_seq_if bus ();

   alu_operand_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Reference 8-bit adder sitting on the adder side-channel.
   assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'h00, bus.add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares each result at the negedge before the consuming edge.
   always @(negedge clk) begin
      if (rst_n && bus.res_valid && bus.res_ready && !bus.clr) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("res_data", {24'h0, bus.res_data}, {24'h0, e.data});
            check("res_flags", {28'h0, bus.res_flags}, {28'h0, e.flags});
         end
      end
   end

   task automatic put_byte(input logic [7:0] d, input logic [1:0] op);
      logic acc;
      int   n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_op    = op;
      forever begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         n++;
         if (n > 50) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic [3:0] ef, input bit push);
      exp_t e;
      e.data  = ed;
      e.flags = ef;
      if (push) sb.push_back(e);
      put_byte(a, op);
      put_byte(b, 2'b00);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!bus.res_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("res_valid_wait", {31'h0, bus.res_valid}, 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("scoreboard_drained", sb.size(), 32'd0);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.clr       = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_op     = 2'b00;
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
      check("rst_res_valid", {31'h0, bus.res_valid}, 32'd0);
      check("rst_add_regs", {15'h0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
      check("rst_result", {20'h0, bus.res_data, bus.res_flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADD 3C+0F with exact two-cycle latency from the B byte.
      send_op(2'b00, 8'h3C, 8'h0F, 8'h4B, 4'b0000, 1'b1);
      @(negedge clk);
      check("lat_ex_not_valid", {31'h0, bus.res_valid}, 32'd0);
      @(negedge clk);
      check("lat_out_valid", {31'h0, bus.res_valid}, 32'd1);
      check("lat_in_ready_low", {31'h0, bus.in_ready}, 32'd0);

      send_op(2'b00, 8'h7F, 8'h01, 8'h80, 4'b1001, 1'b1);
      send_op(2'b00, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b1);
      send_op(2'b01, 8'h00, 8'h00, 8'h01, 4'b0000, 1'b1);
`ifdef ALU_SUB_EN
      send_op(2'b10, 8'h05, 8'h07, 8'hFE, 4'b1000, 1'b1);
      send_op(2'b10, 8'h07, 8'h05, 8'h02, 4'b0010, 1'b1);
`else
      send_op(2'b10, 8'h05, 8'h07, 8'h0C, 4'b0000, 1'b1);
      send_op(2'b10, 8'h07, 8'h05, 8'h0C, 4'b0000, 1'b1);
`endif
      drain();

      // Backpressure: result must hold while res_ready is low.
      bus.res_ready = 1'b0;
      send_op(2'b00, 8'h11, 8'h22, 8'h33, 4'b0000, 1'b1);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_res_valid", {31'h0, bus.res_valid}, 32'd1);
         check("hold_in_ready", {31'h0, bus.in_ready}, 32'd0);
         check("hold_res_data", {24'h0, bus.res_data}, 32'h33);
      end
      @(posedge clk);
      #1;
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_in_ready", {31'h0, bus.in_ready}, 32'd1);

      // Pending result discarded by clr.
      bus.res_ready = 1'b0;
      send_op(2'b00, 8'h80, 8'h80, 8'h00, 4'b0111, 1'b0);
      wait_valid();
      bus.clr = 1'b1;
      @(posedge clk);
      #1;
      bus.clr = 1'b0;
      check("clr_drops_valid", {31'h0, bus.res_valid}, 32'd0);
      check("clr_in_ready", {31'h0, bus.in_ready}, 32'd1);
      bus.res_ready = 1'b1;

      // clr in S_B: byte dropped, carry flag cleared.
      send_op(2'b00, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b1);
      put_byte(8'h00, 2'b01);
      bus.clr      = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      @(posedge clk);
      #1;
      bus.clr      = 1'b0;
      bus.in_valid = 1'b0;
      check("clr_sb_in_ready", {31'h0, bus.in_ready}, 32'd1);
      send_op(2'b01, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b1);
      send_op(2'b00, 8'h01, 8'h01, 8'h02, 4'b0000, 1'b1);
      drain();

      // Asynchronous reset during S_EX.
      send_op(2'b00, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b1);
      drain();
      send_op(2'b00, 8'h10, 8'h20, 8'h30, 4'b0000, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", {31'h0, bus.in_ready}, 32'd1);
      check("arst_res_valid", {31'h0, bus.res_valid}, 32'd0);
      check("arst_add_regs", {15'h0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
      check("arst_result", {20'h0, bus.res_data, bus.res_flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_op(2'b01, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b1);
      send_op(2'b00, 8'h01, 8'h01, 8'h02, 4'b0000, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
